seq_alu: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit combinational ALU. Accepts one operation at a time over a valid/ready input channel, computes single-cycle logic and arithmetic ops or an optional iterative multiply, and presents a registered result with overflow, zero and error flags on a valid/ready output channel. Sits between the decode stage and writeback in the npc datapath.

---
 rtl/seq_alu_pkg.sv | 23 ++
 rtl/seq_alu_mul.sv | 61 ++++++
 rtl/seq_alu.sv | 141 ++++++++++++++
 tb/tb_seq_alu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcodes, widths and FSM state type for the seq_alu block.
// The multiply opcode is legal only when SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_NOT = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_SLT = 4'd6;
  localparam logic [OP_W-1:0] OP_EQ  = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle
// over WIDTH cycles. 'done' is high during the last iteration, and 'product'
// then carries the complete 2*WIDTH-bit result so the caller can register it
// on the same edge that ends the iteration.
module alu_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step;

  // Accumulator value after adding the current partial product.
  assign step    = acc + (mplier[0] ? mcand : '0);
  assign done    = busy & (cnt == LAST);
  assign product = step;

  // Iteration state: load operands on start, then shift and accumulate.
  // The counter parks at LAST after the final iteration instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would chain updates within one edge.
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == LAST) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result and overflow/zero/error flags.
// Define SEQ_ALU_MUL_EN to add the iterative multiply (opcode 8); without it
// every op completes in one cycle and opcode 8 is illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_err
);

  alu_state_t state;

  logic             accept;
  logic             start_mul;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_raw;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             alu_err;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Sign-extended add/sub: overflow shows as disagreement of the top two bits.
  assign sum_ext  = {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};
  assign diff_ext = {in_a[WIDTH-1], in_a} - {in_b[WIDTH-1], in_b};

  // Single-cycle op decode on the live request; the result is registered at accept.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    alu_raw = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_raw = sum_ext[WIDTH-1:0];
        alu_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
      end
      OP_SUB: begin
        alu_raw = diff_ext[WIDTH-1:0];
        alu_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
      end
      OP_NOT: alu_raw = ~in_a;
      OP_AND: alu_raw = in_a & in_b;
      OP_OR:  alu_raw = in_a | in_b;
      OP_XOR: alu_raw = in_a ^ in_b;
      OP_SLT: alu_raw = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_EQ:  alu_raw = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: alu_raw = '0;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  // Overflowed and illegal ops both report a forced-zero result.
  assign alu_result = (alu_ovf | alu_err) ? '0 : alu_raw;

`ifdef SEQ_ALU_MUL_EN
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_ovf;

  assign start_mul = accept & (in_op == OP_MUL) & ~mul_busy;
  assign mul_ovf   = |mul_product[2*WIDTH-1:WIDTH];

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign start_mul = 1'b0;
`endif

  // Control FSM with registered result fields; fields only change when a new
  // result is produced, so they hold steady under output backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b1;
      out_err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (start_mul) begin
              state <= BUSY;
            end else begin
              state        <= DONE;
              out_result   <= alu_result;
              out_overflow <= alu_ovf;
              out_zero     <= (alu_result == '0);
              out_err      <= alu_err;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
`ifdef SEQ_ALU_MUL_EN
        BUSY: begin
          if (mul_done) begin
            state        <= DONE;
            out_result   <= mul_ovf ? '0 : mul_product[WIDTH-1:0];
            out_overflow <= mul_ovf;
            out_zero     <= mul_ovf | (mul_product[WIDTH-1:0] == '0);
            out_err      <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu (WIDTH=4) against an
// arithmetic reference model. Honours SEQ_ALU_MUL_EN like the design.
module tb_seq_alu;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    int result;
    int ovf;
    int zero;
    int err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_overflow;
  logic         out_zero;
  logic         out_err;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v > SMAX) ? v - (1 << W) : v;
  endfunction

  // Reference model: plain integer arithmetic from the opcode definitions.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int   sa = to_signed(a);
    int   sb = to_signed(b);
    int   s;
    e.result = 0; e.ovf = 0; e.err = 0;
    case (op)
      0, 1: begin
        s = (op == 0) ? sa + sb : sa - sb;
        if (s > SMAX || s < SMIN) e.ovf = 1;
        else e.result = s & MASK;
      end
      2: e.result = (~a) & MASK;
      3: e.result = a & b;
      4: e.result = a | b;
      5: e.result = a ^ b;
      6: e.result = (sa < sb) ? 1 : 0;
      7: e.result = (a == b) ? 1 : 0;
      8: begin
        if (!MUL_EN) e.err = 1;
        else if (a * b > MASK) e.ovf = 1;
        else e.result = a * b;
      end
      default: e.err = 1;
    endcase
    e.zero = (e.result == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic int latency(input int op);
    return (op == 8 && MUL_EN) ? W + 1 : 1;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".result"}, int'(out_result), e.result);
    check({tag, ".ovf"}, int'(out_overflow), e.ovf);
    check({tag, ".zero"}, int'(out_zero), e.zero);
    check({tag, ".err"}, int'(out_err), e.err);
  endtask

  // Issue one op from an idle block; scramble inputs after accept, then wait
  // for out_valid with a bounded budget and check latency and fields.
  task automatic do_op(input string tag, input int op, input int a, input int b,
                       input bit hold);
    exp_t e = model(op, a, b);
    int   cyc = 0;
    @(negedge clk);
    check({tag, ".in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1; in_op = 4'(op); in_a = W'(a); in_b = W'(b);
    out_ready = !hold;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 4'($urandom); in_a = W'($urandom); in_b = W'($urandom);
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    check({tag, ".latency"}, cyc, latency(op));
    check_out(tag, e);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, int'(out_valid), 1);
        check({tag, ".hold_in_ready"}, int'(in_ready), 0);
        check_out({tag, ".hold"}, e);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
  endtask

  typedef struct { int op; int a; int b; } vec_t;
  vec_t dir[10] = '{
    '{0, 7, 1}, '{1, 8, 1}, '{1, 3, 5}, '{6, 13, 2}, '{7, 5, 5},
    '{5, 10, 5}, '{8, 3, 5}, '{8, 5, 4}, '{12, 3, 3}, '{2, 5, 0}
  };

  initial begin
    exp_t e;
    vec_t q[$];
    vec_t v;
    int   cyc;

    #12;
    check("reset.in_ready", int'(in_ready), 1);
    check("reset.out_valid", int'(out_valid), 0);
    e.result = 0; e.ovf = 0; e.zero = 1; e.err = 0;
    check_out("reset", e);
    rst_n = 1'b1;

    foreach (dir[i]) do_op($sformatf("dir%0d", i), dir[i].op, dir[i].a, dir[i].b, 1'b0);

    // Backpressure on a plain op and, if present, on a multiply.
    do_op("bp_xor", 5, 10, 5, 1'b1);
    do_op("bp_mul", 8, 3, 5, 1'b1);

    // Back-to-back single-cycle ops with out_ready held high.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("b2b.valid", int'(out_valid), 1);
        check_out("b2b", model(v.op, v.a, v.b));
      end
      if (i < 8) begin
        v.op = int'($urandom_range(0, 7)); v.a = int'($urandom_range(0, MASK));
        v.b = int'($urandom_range(0, MASK));
        check("b2b.in_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_op = 4'(v.op); in_a = W'(v.a); in_b = W'(v.b);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b.drain", int'(out_valid), 0);

    // Random single ops over the full opcode space.
    for (int i = 0; i < 40; i++)
      do_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, MASK)), 1'b0);

    // Reset while a result is held, then while a multiply is in flight.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      out_ready = (k == 1);
      in_valid = 1'b1; in_op = (k == 0) ? 4'd0 : 4'd8; in_a = 4'd3; in_b = 4'd3;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid.out_valid", int'(out_valid), 0);
      check("rst_mid.in_ready", int'(in_ready), 1);
      e.result = 0; e.ovf = 0; e.zero = 1; e.err = 0;
      check_out("rst_mid", e);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      cyc = 0;
      repeat (W + 2) begin
        @(negedge clk);
        if (out_valid) cyc++;
      end
      check("rst_mid.no_stale", cyc, 0);
      do_op("after_rst", 8, 2, 7, 1'b0);
      do_op("after_rst", 1, 3, 5, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
